// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD command scheduler: FSM state
// encoding, the long-settle command codes and the power-on init sequence.
package lcd_sched_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_INIT    = 3'd1,
    ST_IDLE    = 3'd2,
    ST_SETUP   = 3'd3,
    ST_PULSE   = 3'd4,
    ST_HOLD    = 3'd5,
    ST_WAIT    = 3'd6
  } state_t;

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;
  localparam int         INIT_LEN  = 4;

  // Init ROM: function set 8-bit/2-line, display on, entry mode, clear.
  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h06;
      default: b = LCD_CLEAR;
    endcase
    return b;
  endfunction

  // Clear and home are the only commands needing the long settle time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && ((d == LCD_CLEAR) || (d == LCD_HOME));
  endfunction

endpackage

// File: rtl/lcd_cmd_scheduler_if.sv
// Requester handshakes plus LCD bus outputs of the LCD command scheduler.
// master: the side supplying bytes and watching the bus; slave: the scheduler.
interface lcd_cmd_scheduler_if;
  logic       req0_valid_i;
  logic       req0_rs_i;
  logic [7:0] req0_data_i;
  logic       req0_ready_o;
  logic       req1_valid_i;
  logic       req1_rs_i;
  logic [7:0] req1_data_i;
  logic       req1_ready_o;
  logic [7:0] lcd_data_o;
  logic       lcd_rs_o;
  logic       lcd_enable_o;
  logic       busy_o;

  modport master (
    output req0_valid_i, req0_rs_i, req0_data_i,
    output req1_valid_i, req1_rs_i, req1_data_i,
    input  req0_ready_o, req1_ready_o,
    input  lcd_data_o, lcd_rs_o, lcd_enable_o, busy_o
  );

  modport slave (
    input  req0_valid_i, req0_rs_i, req0_data_i,
    input  req1_valid_i, req1_rs_i, req1_data_i,
    output req0_ready_o, req1_ready_o,
    output lcd_data_o, lcd_rs_o, lcd_enable_o, busy_o
  );
endinterface

// File: rtl/lcd_sched_timer.sv
// Loadable down-counter shared by every timed state of the scheduler.
// A load of N-1 makes o_done rise after N cycles; load wins over counting.
module lcd_sched_timer #(
  parameter int CNT_W = 18
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)             r_count <= '0;
    else if (i_load)            r_count <= i_load_val;
    else if (r_count != '0)     r_count <= r_count - CNT_W'(1);
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// Two-requester round-robin scheduler driving an HD44780-style LCD bus.
// Each accepted byte goes through SETUP, PULSE (enable high), HOLD and a
// settle WAIT sized by the command type before the next byte is accepted.
// Optional: define LCD_SCHED_INIT_EN to add a power-on delay followed by
// an automatic four-command init sequence before requests are served.
module lcd_cmd_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int SETUP_CYCLES      = 1,
  parameter int EN_HIGH_CYCLES    = 6,
  parameter int CHAR_WAIT_CYCLES  = 480,
  parameter int CLEAR_WAIT_CYCLES = 19680,
  parameter int POWERUP_CYCLES    = 180000
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  lcd_cmd_scheduler_if.slave  bus
);

  // Every wait parameter must be at least 1.
  localparam int MAX_A = (SETUP_CYCLES > EN_HIGH_CYCLES) ? SETUP_CYCLES : EN_HIGH_CYCLES;
  localparam int MAX_B = (CHAR_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CHAR_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
`ifdef LCD_SCHED_INIT_EN
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_W = (MAX_C > POWERUP_CYCLES) ? MAX_C : POWERUP_CYCLES;
`else
  localparam int MAX_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;
`endif
  localparam int CNT_W = $clog2(MAX_W + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(EN_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHAR_LD  = CNT_W'(CHAR_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLEAR_WAIT_CYCLES - 1);
`ifdef LCD_SCHED_INIT_EN
  // The first POWERUP cycle is spent loading, so the counter covers the rest.
  localparam logic [CNT_W-1:0] PU_LD    = CNT_W'((POWERUP_CYCLES >= 2) ? POWERUP_CYCLES - 2 : 0);
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_data;
  logic             r_rs;
  logic             r_last_grant;   // 1: requester 1 was served last
  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_idle;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_done;
`ifdef LCD_SCHED_INIT_EN
  logic             r_pu_arm;
  logic             r_init_busy;
  logic [2:0]       r_init_idx;
`endif

  assign w_idle = (r_state == ST_IDLE);

  // Round-robin grant: on a tie the requester not served last wins.
  // Gated by reset so nothing is offered while the block is held in reset.
  assign w_rdy0 = reset_n_i && w_idle && bus.req0_valid_i && (!bus.req1_valid_i || r_last_grant);
  assign w_rdy1 = reset_n_i && w_idle && bus.req1_valid_i && (!bus.req0_valid_i || !r_last_grant);

  lcd_sched_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // Next-state and timer-load decode for the transfer sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_rdy0 || w_rdy1) begin
          w_state_nxt = ST_SETUP;
          w_load      = 1'b1;
          w_load_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (w_done) begin
          w_state_nxt = ST_PULSE;
          w_load      = 1'b1;
          w_load_val  = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (w_done) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_state_nxt = ST_WAIT;
        w_load      = 1'b1;
        w_load_val  = is_long_cmd(r_rs, r_data) ? CLR_LD : CHAR_LD;
      end
      ST_WAIT: begin
        if (w_done) begin
`ifdef LCD_SCHED_INIT_EN
          if (r_init_busy && (r_init_idx != 3'(INIT_LEN))) w_state_nxt = ST_INIT;
          else                                            w_state_nxt = ST_IDLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef LCD_SCHED_INIT_EN
      ST_POWERUP: begin
        if (!r_pu_arm) begin
          if (POWERUP_CYCLES < 2) begin
            w_state_nxt = ST_INIT;
          end else begin
            w_load     = 1'b1;
            w_load_val = PU_LD;
          end
        end else if (w_done) begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_INIT: begin
        w_state_nxt = ST_SETUP;
        w_load      = 1'b1;
        w_load_val  = SETUP_LD;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset lands in POWERUP when init is built in.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
`ifdef LCD_SCHED_INIT_EN
    if (!reset_n_i) r_state <= ST_POWERUP;
`else
    if (!reset_n_i) r_state <= ST_IDLE;
`endif
    else            r_state <= w_state_nxt;
  end

  // Capture the granted byte (or init ROM byte) and remember who was served.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_data       <= 8'h00;
      r_rs         <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_rdy0) begin
      r_data       <= bus.req0_data_i;
      r_rs         <= bus.req0_rs_i;
      r_last_grant <= 1'b0;
    end else if (w_rdy1) begin
      r_data       <= bus.req1_data_i;
      r_rs         <= bus.req1_rs_i;
      r_last_grant <= 1'b1;
`ifdef LCD_SCHED_INIT_EN
    end else if (r_state == ST_INIT) begin
      r_data       <= init_rom(r_init_idx[1:0]);
      r_rs         <= 1'b0;
`endif
    end
  end

`ifdef LCD_SCHED_INIT_EN
  // Power-up arming and progress through the init ROM.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pu_arm    <= 1'b0;
      r_init_busy <= 1'b1;
      r_init_idx  <= 3'd0;
    end else begin
      if (r_state == ST_POWERUP) r_pu_arm <= 1'b1;
      if (r_state == ST_INIT)    r_init_idx <= r_init_idx + 3'd1;
      if ((r_state == ST_WAIT) && w_done && (r_init_idx == 3'(INIT_LEN)))
        r_init_busy <= 1'b0;
    end
  end
`endif

  assign bus.req0_ready_o = w_rdy0;
  assign bus.req1_ready_o = w_rdy1;
  assign bus.lcd_data_o   = r_data;
  assign bus.lcd_rs_o     = r_rs;
  assign bus.lcd_enable_o = (r_state == ST_PULSE);
  assign bus.busy_o       = !w_idle;

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed bench for lcd_cmd_scheduler: a vector table of single transfers
// and arbitration ties, plus sequences for busy-time pulses, mid-pulse reset
// and (when LCD_SCHED_INIT_EN is defined) the power-on init sequence.
module tb_lcd_cmd_scheduler;

  localparam int SETUP  = 1;
  localparam int ENH    = 6;
  localparam int CHAR_W = 480;
`ifdef LCD_SCHED_INIT_EN
  localparam int CLR_W  = 2000;
  localparam int PU     = 200;
`else
  localparam int CLR_W  = 19680;
  localparam int PU     = 180000;
`endif
  localparam int MAXC   = 30000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_cmd_scheduler_if bus_if();

  lcd_cmd_scheduler #(
    .SETUP_CYCLES      (SETUP),
    .EN_HIGH_CYCLES    (ENH),
    .CHAR_WAIT_CYCLES  (CHAR_W),
    .CLEAR_WAIT_CYCLES (CLR_W),
    .POWERUP_CYCLES    (PU)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus_if)
  );

  typedef struct {
    logic       v0;
    logic       rs0;
    logic [7:0] d0;
    logic       v1;
    logic       rs1;
    logic [7:0] d1;
    logic       g;     // expected grant
    logic [7:0] ed;    // expected lcd data
    logic       er;    // expected lcd rs
    int         ew;    // expected settle wait
  } vec_t;

  vec_t vt[9];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (bus_if.busy_o && c < maxc) begin
      step();
      c++;
    end
    if (bus_if.busy_o) chk("idle_timeout", 32'(bus_if.busy_o), 32'd0);
  endtask

  task automatic drop_reqs();
    bus_if.req0_valid_i = 1'b0;
    bus_if.req1_valid_i = 1'b0;
    bus_if.req0_data_i  = 8'hFF;
    bus_if.req1_data_i  = 8'hEE;
    bus_if.req0_rs_i    = 1'b1;
    bus_if.req1_rs_i    = 1'b0;
  endtask

  // Apply one table vector starting in an IDLE cycle and time the transfer.
  task automatic run_vec(input int i);
    int c, first, last, idle;
    logic held;
    bus_if.req0_valid_i = vt[i].v0;
    bus_if.req0_rs_i    = vt[i].rs0;
    bus_if.req0_data_i  = vt[i].d0;
    bus_if.req1_valid_i = vt[i].v1;
    bus_if.req1_rs_i    = vt[i].rs1;
    bus_if.req1_data_i  = vt[i].d1;
    #1;
    chk($sformatf("v%0d_rdy0", i), 32'(bus_if.req0_ready_o), 32'(vt[i].g == 1'b0));
    chk($sformatf("v%0d_rdy1", i), 32'(bus_if.req1_ready_o), 32'(vt[i].g == 1'b1));
    step();
    drop_reqs();
    chk($sformatf("v%0d_data", i), 32'(bus_if.lcd_data_o), 32'(vt[i].ed));
    chk($sformatf("v%0d_rs", i),   32'(bus_if.lcd_rs_o),   32'(vt[i].er));
    c = 1; first = -1; last = -1; idle = -1; held = 1'b1;
    while (c < MAXC) begin
      if (!bus_if.busy_o) begin
        idle = c;
        break;
      end
      if (bus_if.lcd_enable_o) begin
        if (first < 0) first = c;
        last = c;
      end
      if (bus_if.lcd_data_o !== vt[i].ed) held = 1'b0;
      step();
      c++;
    end
    chk($sformatf("v%0d_en_first", i), 32'(first), 32'(SETUP + 1));
    chk($sformatf("v%0d_en_last", i),  32'(last),  32'(SETUP + ENH));
    chk($sformatf("v%0d_idle_cyc", i), 32'(idle),  32'(SETUP + ENH + vt[i].ew + 2));
    chk($sformatf("v%0d_held", i),     32'(held),  32'd1);
  endtask

`ifdef LCD_SCHED_INIT_EN
  // Observe the init sequence with req0 held valid the whole time.
  task automatic run_init();
    logic [7:0] seen[8];
    int   nb = 0;
    int   c = 1;
    logic prev_en = 1'b0;
    logic bad_rdy = 1'b0;
    bus_if.req0_valid_i = 1'b1;
    bus_if.req0_data_i  = 8'h99;
    while (c < PU + 4 * (CLR_W + 100) && bus_if.busy_o) begin
      if (bus_if.req0_ready_o) bad_rdy = 1'b1;
      if (bus_if.lcd_enable_o && !prev_en && nb < 8) begin
        seen[nb] = bus_if.lcd_data_o;
        nb++;
      end
      prev_en = bus_if.lcd_enable_o;
      step();
      c++;
    end
    chk("init_idle_cyc", 32'(c), 32'(PU + 3 * (SETUP + ENH + CHAR_W + 2) + (SETUP + ENH + CLR_W + 2)));
    chk("init_no_rdy",   32'(bad_rdy), 32'd0);
    chk("init_nbytes",   32'(nb), 32'd4);
    chk("init_b0", 32'(seen[0]), 32'h38);
    chk("init_b1", 32'(seen[1]), 32'h0C);
    chk("init_b2", 32'(seen[2]), 32'h06);
    chk("init_b3", 32'(seen[3]), 32'h01);
    chk("init_rdy_at_idle", 32'(bus_if.req0_ready_o), 32'd1);
    drop_reqs();
  endtask
`endif

  initial begin
    vt[0] = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 8'h41, 1'b1, CHAR_W};
    vt[1] = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, CLR_W};
    vt[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b1, 8'h02, 1'b0, CLR_W};
    vt[3] = '{1'b1, 1'b1, 8'h30, 1'b1, 1'b1, 8'h31, 1'b0, 8'h30, 1'b1, CHAR_W};
    vt[4] = '{1'b1, 1'b1, 8'h32, 1'b1, 1'b1, 8'h33, 1'b1, 8'h33, 1'b1, CHAR_W};
    vt[5] = '{1'b1, 1'b1, 8'h34, 1'b1, 1'b1, 8'h35, 1'b0, 8'h34, 1'b1, CHAR_W};
    vt[6] = '{1'b1, 1'b0, 8'h36, 1'b1, 1'b1, 8'h37, 1'b1, 8'h37, 1'b1, CHAR_W};
    vt[7] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, CHAR_W};
    vt[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, 8'h03, 1'b0, CHAR_W};

    // Reset phase: requests offered but nothing may be granted.
    bus_if.req0_valid_i = 1'b1;
    bus_if.req0_rs_i    = 1'b1;
    bus_if.req0_data_i  = 8'hA5;
    bus_if.req1_valid_i = 1'b1;
    bus_if.req1_rs_i    = 1'b1;
    bus_if.req1_data_i  = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(bus_if.lcd_data_o),   32'd0);
    chk("rst_rs",   32'(bus_if.lcd_rs_o),     32'd0);
    chk("rst_en",   32'(bus_if.lcd_enable_o), 32'd0);
    chk("rst_rdy0", 32'(bus_if.req0_ready_o), 32'd0);
    chk("rst_rdy1", 32'(bus_if.req1_ready_o), 32'd0);
    drop_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
`ifdef LCD_SCHED_INIT_EN
    run_init();
    step();
`else
    chk("post_rst_busy", 32'(bus_if.busy_o), 32'd0);
`endif

    for (int i = 0; i < 9; i++) run_vec(i);

    // A req1 pulse while busy must be ignored.
    bus_if.req0_valid_i = 1'b1;
    bus_if.req0_rs_i    = 1'b1;
    bus_if.req0_data_i  = 8'h41;
    step();
    drop_reqs();
    step();
    bus_if.req1_valid_i = 1'b1;
    bus_if.req1_data_i  = 8'hAA;
    bus_if.req1_rs_i    = 1'b1;
    #1;
    chk("busy_pulse_rdy1", 32'(bus_if.req1_ready_o), 32'd0);
    step();
    drop_reqs();
    wait_idle(MAXC);
    repeat (3) step();
    chk("busy_pulse_nobusy", 32'(bus_if.busy_o),     32'd0);
    chk("busy_pulse_data",   32'(bus_if.lcd_data_o), 32'h41);

    // Reset during PULSE after a req0 grant: outputs clear at once, and the
    // next tie goes to req0 again because last_grant is reset.
    bus_if.req0_valid_i = 1'b1;
    bus_if.req0_rs_i    = 1'b1;
    bus_if.req0_data_i  = 8'h55;
    step();
    drop_reqs();
    step();
    chk("pre_abort_en", 32'(bus_if.lcd_enable_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_en",   32'(bus_if.lcd_enable_o), 32'd0);
    chk("abort_data", 32'(bus_if.lcd_data_o),   32'd0);
    chk("abort_rs",   32'(bus_if.lcd_rs_o),     32'd0);
    @(negedge clk);
    bus_if.req0_valid_i = 1'b1;
    bus_if.req0_data_i  = 8'h61;
    bus_if.req1_valid_i = 1'b1;
    bus_if.req1_data_i  = 8'h62;
    rst_n = 1'b1;
    #1;
`ifdef LCD_SCHED_INIT_EN
    step();
    wait_idle(PU + 4 * (CLR_W + 100));
`else
    chk("abort_busy", 32'(bus_if.busy_o), 32'd0);
`endif
    chk("abort_tie_rdy0", 32'(bus_if.req0_ready_o), 32'd1);
    chk("abort_tie_rdy1", 32'(bus_if.req1_ready_o), 32'd0);
    step();
    drop_reqs();
    chk("abort_tie_data", 32'(bus_if.lcd_data_o), 32'h61);
    wait_idle(MAXC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
